dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported, synchronous-read data memory between the core load/store unit (port 0) and a secondary master such as a debug or DMA loader (port 1). It sits between both requesters and the data memory's `i_addr`/`i_wdata`/`i_wen`/`o_rdata` port. It grants at most one access per cycle and drives the winning request combinationally onto the memory. It returns read data with a per-port valid pulse one cycle later. Port 0 has fixed priority, and a bounded-wait counter guarantees progress for port 1; a compile-time option replaces this with round-robin.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory bus bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8
);
    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic [DATA_BYTES-1:0] p0_wen;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic [DATA_BYTES-1:0] p1_wen;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_BYTES-1:0] mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_addr, p0_wdata, p0_wen,
        input  p1_req, p1_addr, p1_wdata, p1_wen,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output p0_req, p0_addr, p0_wdata, p0_wen,
        output p1_req, p1_addr, p1_wdata, p1_wen,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, fixed priority with aging or round-robin (DMEM_ARB_RR_EN)
// Grants one access per cycle combinationally; read data returns with a one-cycle rvalid pulse.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int MAX_WAIT   = 4
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_P0   = 2'd1,
        SEL_P1   = 2'd2
    } sel_e;

    sel_e w_sel;
    logic w_p0_gnt;
    logic w_p1_gnt;
    logic r_p0_rvalid;
    logic r_p1_rvalid;

`ifdef DMEM_ARB_RR_EN
    // Resets to "port 1 last" so the first tie after reset goes to port 0.
    logic r_last_p1;

    always_comb begin
        w_sel = SEL_NONE;
        if (rst) begin
            w_sel = SEL_NONE;
        end else if (bus.p0_req && bus.p1_req) begin
            w_sel = r_last_p1 ? SEL_P0 : SEL_P1;
        end else if (bus.p0_req) begin
            w_sel = SEL_P0;
        end else if (bus.p1_req) begin
            w_sel = SEL_P1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_p1 <= 1'b1;
        end else if (w_sel == SEL_P0) begin
            r_last_p1 <= 1'b0;
        end else if (w_sel == SEL_P1) begin
            r_last_p1 <= 1'b1;
        end
    end
`else
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_aged;

    assign w_aged = (r_wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        w_sel = SEL_NONE;
        if (rst) begin
            w_sel = SEL_NONE;
        end else if (bus.p0_req && bus.p1_req) begin
            w_sel = w_aged ? SEL_P1 : SEL_P0;
        end else if (bus.p0_req) begin
            w_sel = SEL_P0;
        end else if (bus.p1_req) begin
            w_sel = SEL_P1;
        end
    end

    // Counts consecutive denied port-1 cycles, saturating once port 1 is owed the grant.
    always_ff @(posedge clk) begin
        if (rst || !bus.p1_req || w_p1_gnt) begin
            r_wait_cnt <= '0;
        end else if (!w_aged) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`endif

    assign w_p0_gnt = (w_sel == SEL_P0);
    assign w_p1_gnt = (w_sel == SEL_P1);

    assign bus.p0_gnt    = w_p0_gnt;
    assign bus.p1_gnt    = w_p1_gnt;
    assign bus.mem_addr  = w_p0_gnt ? bus.p0_addr  : (w_p1_gnt ? bus.p1_addr  : '0);
    assign bus.mem_wdata = w_p0_gnt ? bus.p0_wdata : (w_p1_gnt ? bus.p1_wdata : '0);
    assign bus.mem_wen   = w_p0_gnt ? bus.p0_wen   : (w_p1_gnt ? bus.p1_wen   : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
        end else begin
            r_p0_rvalid <= w_p0_gnt && (bus.p0_wen == '0);
            r_p1_rvalid <= w_p1_gnt && (bus.p1_wen == '0);
        end
    end

    // Gating with rst also kills a pulse loaded on the edge just before reset rose.
    assign bus.p0_rvalid = r_p0_rvalid && !rst;
    assign bus.p1_rvalid = r_p1_rvalid && !rst;
    assign bus.p0_rdata  = bus.mem_rdata;
    assign bus.p1_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a per-cycle reference model
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(64)) bus ();

    dmem_arbiter #(.DATA_WIDTH(64), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_val(input int i);
        return (i == 3) ? 64'hDEAD : {32'hC0DE_0000, 32'(i)};
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'(a[8:3]);
    endfunction

    // Synchronous-read, byte-writable data memory
    logic [63:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_val(i);
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            for (int b = 0; b < 8; b++)
                if (bus.mem_wen[b]) mem[widx(bus.mem_addr)][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            bus.mem_rdata <= mem[widx(bus.mem_addr)];
        end
    end

    // Reference model: checks every cycle at negedge, then advances to the next cycle's state
    logic [63:0] mdl_mem [0:63];
    int          m_p1_denied = 0;
    int          m_last_winner = 1;
    bit          m_pend0 = 0, m_pend1 = 0;
    logic [63:0] m_data0 = '0, m_data1 = '0;

    initial begin
        bit          eg0, eg1;
        logic [63:0] ea, ed;
        logic [7:0]  ew;
        for (int i = 0; i < 64; i++) mdl_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            eg0 = 0;
            eg1 = 0;
            if (!rst) begin
                if (bus.p0_req && bus.p1_req) begin
`ifdef DMEM_ARB_RR_EN
                    if (m_last_winner == 1) eg0 = 1; else eg1 = 1;
`else
                    if (m_p1_denied >= MAX_WAIT) eg1 = 1; else eg0 = 1;
`endif
                end else begin
                    eg0 = bus.p0_req;
                    eg1 = bus.p1_req;
                end
            end
            ea = eg0 ? bus.p0_addr  : (eg1 ? bus.p1_addr  : 64'h0);
            ed = eg0 ? bus.p0_wdata : (eg1 ? bus.p1_wdata : 64'h0);
            ew = eg0 ? bus.p0_wen   : (eg1 ? bus.p1_wen   : 8'h0);
            check("p0_gnt", 64'(bus.p0_gnt), 64'(eg0));
            check("p1_gnt", 64'(bus.p1_gnt), 64'(eg1));
            check("mem_addr", bus.mem_addr, ea);
            check("mem_wdata", bus.mem_wdata, ed);
            check("mem_wen", 64'(bus.mem_wen), 64'(ew));
            check("p0_rvalid", 64'(bus.p0_rvalid), 64'(m_pend0 && !rst));
            check("p1_rvalid", 64'(bus.p1_rvalid), 64'(m_pend1 && !rst));
            if (m_pend0 && !rst) check("p0_rdata", bus.p0_rdata, m_data0);
            if (m_pend1 && !rst) check("p1_rdata", bus.p1_rdata, m_data1);

            if (rst) begin
                m_p1_denied   = 0;
                m_last_winner = 1;
                m_pend0       = 0;
                m_pend1       = 0;
            end else begin
                m_pend0 = eg0 && (bus.p0_wen == 8'h0);
                m_pend1 = eg1 && (bus.p1_wen == 8'h0);
                m_data0 = mdl_mem[widx(bus.p0_addr)];
                m_data1 = mdl_mem[widx(bus.p1_addr)];
                m_p1_denied = (bus.p1_req && !eg1) ? m_p1_denied + 1 : 0;
                if (eg0) m_last_winner = 0;
                if (eg1) m_last_winner = 1;
                for (int b = 0; b < 8; b++)
                    if (ew[b]) mdl_mem[widx(ea)][b*8 +: 8] = ed[b*8 +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] pat12;
    logic [4:0]  pat5;

    initial begin
        rst = 1'b1;
        bus.p0_req = 1'b1; bus.p0_addr = 64'h08; bus.p0_wdata = '0; bus.p0_wen = 8'h00;
        bus.p1_req = 1'b1; bus.p1_addr = 64'h10; bus.p1_wdata = '0; bus.p1_wen = 8'hFF;
        #2;
        check("rst_p0_gnt", 64'(bus.p0_gnt), 64'd0);
        check("rst_p1_gnt", 64'(bus.p1_gnt), 64'd0);
        check("rst_mem_wen", 64'(bus.mem_wen), 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        repeat (3) tick();
        check("rst_p0_rvalid", 64'(bus.p0_rvalid), 64'd0);
        check("rst_p1_rvalid", 64'(bus.p1_rvalid), 64'd0);

        rst = 1'b0;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        #1;
        check("idle_mem_addr", bus.mem_addr, 64'd0);
        check("idle_mem_wen", 64'(bus.mem_wen), 64'd0);
        tick();

        bus.p1_req = 1'b1; bus.p1_addr = 64'h18; bus.p1_wen = 8'h00;
        #1;
        check("rd_p1_gnt", 64'(bus.p1_gnt), 64'd1);
        tick();
        bus.p1_req = 1'b0;
        #1;
        check("rd_p1_rvalid", 64'(bus.p1_rvalid), 64'd1);
        check("rd_p1_rdata", bus.p1_rdata, 64'hDEAD);
        check("rd_p0_rvalid", 64'(bus.p0_rvalid), 64'd0);

        bus.p0_req = 1'b1; bus.p0_addr = 64'h20; bus.p0_wen = 8'h01; bus.p0_wdata = 64'hAB;
        #1;
        check("wr_p0_gnt", 64'(bus.p0_gnt), 64'd1);
        tick();
        bus.p0_wen = 8'h00;
        #1;
        check("wr_no_rvalid", 64'(bus.p0_rvalid), 64'd0);
        tick();
        bus.p0_req = 1'b0;
        #1;
        check("rb_p0_rvalid", 64'(bus.p0_rvalid), 64'd1);
        check("rb_low_byte", 64'(bus.p0_rdata[7:0]), 64'hAB);

        bus.p1_req = 1'b1; bus.p1_addr = 64'h18; bus.p1_wen = 8'hFF; bus.p1_wdata = 64'hBEEF;
        tick();
        bus.p1_req = 1'b0; bus.p1_wen = 8'h00;
        bus.p0_req = 1'b1; bus.p0_addr = 64'h18;
        #1;
        check("wr1_no_rvalid", 64'(bus.p1_rvalid), 64'd0);
        tick();
        bus.p0_req = 1'b0;
        #1;
        check("rb1_p0_rdata", bus.p0_rdata, 64'hBEEF);

        bus.p0_req = 1'b1; bus.p0_addr = 64'h28; bus.p0_wen = 8'h00;
        bus.p1_req = 1'b1; bus.p1_addr = 64'h30; bus.p1_wen = 8'h00;
        for (int i = 0; i < 12; i++) begin
            #1;
            pat12[i] = bus.p1_gnt;
            tick();
        end
`ifdef DMEM_ARB_RR_EN
        check("contend_pattern", 64'(pat12), 64'h555);
`else
        check("contend_pattern", 64'(pat12), 64'h210);
`endif
        rst = 1'b1;
        #1;
        check("mrst_p0_rvalid", 64'(bus.p0_rvalid), 64'd0);
        check("mrst_p1_rvalid", 64'(bus.p1_rvalid), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            pat5[i] = bus.p1_gnt;
            tick();
        end
`ifdef DMEM_ARB_RR_EN
        check("post_rst_pattern", 64'(pat5), 64'h0A);
`else
        check("post_rst_pattern", 64'(pat5), 64'h10);
`endif
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
